// File: rtl/vector_pkg.sv
// Shared types and width helpers for the vector packer: FSM state encoding
// and the slot-index / word-count widths derived from NUM_INPUTS.
package vector_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    // IDX_W: slot index width, at least one bit even for a single-slot vector.
    function automatic int idx_width(input int num_inputs);
        return (num_inputs > 1) ? $clog2(num_inputs) : 1;
    endfunction

    // CNT_W: width able to hold counts 0..NUM_INPUTS.
    function automatic int cnt_width(input int num_inputs);
        return $clog2(num_inputs + 1);
    endfunction

endpackage

// File: rtl/vector_packer_wrap_counter.sv
// Slot index 0..MAX-1 that wraps on increment, with clear and load.
module wrap_counter
#(
    parameter int MAX = 2,
    parameter int W   = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= (value == W'(MAX - 1)) ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/vector_packer.sv
// Collects WIDTH-bit words into a NUM_INPUTS*WIDTH vector (first word in the
// top slot) and offers it downstream; flush closes a partial vector, zero padded.
module vector_packer
    import vector_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 2
)
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              flush,
    output logic [NUM_INPUTS*WIDTH-1:0]       out_data,
    output logic [cnt_width(NUM_INPUTS)-1:0]  out_count,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int IDX_W = idx_width(NUM_INPUTS);
    localparam int CNT_W = cnt_width(NUM_INPUTS);
    localparam int VEC_W = NUM_INPUTS * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high. in_ready depends only on state and out_ready, so a held
    // vector can drain and a new word enter in the same cycle.

    state_t             state;
    state_t             state_n;
    logic [VEC_W-1:0]   data_n;
    logic [CNT_W-1:0]   count_n;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_load_value;
    logic               idx_clear;
    logic               idx_inc;
    logic               idx_load;
    logic               word_acc;
    logic               out_acc;

    assign out_valid = (state == FULL);
    assign in_ready  = (state == FILL) | out_ready;
    assign word_acc  = in_valid & in_ready;
    assign out_acc   = out_valid & out_ready;

    wrap_counter #(
        .MAX (NUM_INPUTS),
        .W   (IDX_W)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .clear      (idx_clear),
        .inc        (idx_inc),
        .load       (idx_load),
        .load_value (idx_load_value),
        .value      (idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            state     <= state_n;
            out_data  <= data_n;
            out_count <= count_n;
        end
    end

    always_comb begin
        state_n        = state;
        data_n         = out_data;
        count_n        = out_count;
        idx_clear      = 1'b0;
        idx_inc        = 1'b0;
        idx_load       = 1'b0;
        idx_load_value = '0;

        if (state == FILL) begin
            if (word_acc) begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (k == int'(idx)) begin
                        data_n[(NUM_INPUTS - k) * WIDTH - 1 -: WIDTH] = in_data;
                    end
                end
                if (idx == LAST_IDX) begin
                    state_n   = FULL;
                    count_n   = CNT_W'(NUM_INPUTS);
                    idx_clear = 1'b1;
                end else if (flush) begin
                    // Word stored first, then everything below it padded.
                    for (int k = 0; k < NUM_INPUTS; k++) begin
                        if (k > int'(idx)) begin
                            data_n[(NUM_INPUTS - k) * WIDTH - 1 -: WIDTH] = '0;
                        end
                    end
                    state_n   = FULL;
                    count_n   = CNT_W'(idx) + CNT_W'(1);
                    idx_clear = 1'b1;
                end else begin
                    idx_inc = 1'b1;
                end
            end else if (flush && (idx != '0)) begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (k >= int'(idx)) begin
                        data_n[(NUM_INPUTS - k) * WIDTH - 1 -: WIDTH] = '0;
                    end
                end
                state_n   = FULL;
                count_n   = CNT_W'(idx);
                idx_clear = 1'b1;
            end
        end else begin
            if (out_acc) begin
                data_n  = '0;
                count_n = '0;
                if (word_acc) begin
                    data_n[VEC_W-1 -: WIDTH] = in_data;
                    if (NUM_INPUTS == 1) begin
                        // A single word already completes the next vector.
                        count_n = CNT_W'(1);
                    end else begin
                        state_n        = FILL;
                        idx_load       = 1'b1;
                        idx_load_value = IDX_W'(1);
                    end
                end else begin
                    state_n   = FILL;
                    idx_clear = 1'b1;
                end
            end
        end
    end

endmodule
